switch_sequencer: RTL and testbench
===================================

# switch_sequencer

Drives the lamp's single switch line so that the three-colour lamp controller lands on a requested colour. It is the transmit side of the toggle protocol the lamp decodes: a toggle is a short low pulse (under the lamp's 1 s wait timeout) that advances the colour, and a long low hold turns the lamp off. It sits between a host/test controller and the lamp's `fake_switch` input. It keeps an internal model of the lamp's colour and emits the minimum toggle sequence to reach the target.

## Interface
- `DIV`, 5000: Sys_CLK cycles per tick (0.1 ms at 50 MHz).
- `HOLD_TICKS`, 2000: ticks the line is held high per "on" phase.
- `GAP_TICKS`, 2000: ticks the line is held low per advance toggle; must be < lamp timeout.
- `OFF_TICKS`, 15000: ticks the line is held low to force the lamp off; must be > lamp timeout.
- `Sys_CLK  in  1`  clock.
- `Sys_RST  in  1`  reset, synchronous, active-high.
- `req_valid  in  1`  request strobe.
- `req_color  in  2`  target: 0 = off, 1 = white, 2 = sun, 3 = yellow.
- `req_ready  out  1`  equals ~busy.
- `busy  out  1`  sequence in progress.
- `done  out  1`  one-cycle pulse when the sequence completes.
- `cur_color  out  2`  modelled lamp colour, same encoding as `req_color`.
- `fake_switch  out  1`  switch line to the lamp.

## Operation
- Reset values: `fake_switch`=0, `cur_color`=0, `busy`=0, `done`=0, `req_ready`=1, FSM in IDLE, counters cleared.
- A request is accepted when `req_valid && req_ready`. `req_color` is latched on acceptance. While busy, `req_valid` is ignored; nothing is queued.
- Colour cycle modelled: white→sun→yellow→white. steps = (target − cur + 3) mod 3.
- Plan on accept:
  - target == cur: go straight to DONE. No line activity.
  - target == 0, cur ≠ 0: OFF.
  - cur == 0, target ≠ 0: RAISE (the lamp lights white), then target−1 × (DROP, RAISE).
  - both ≠ 0: steps × (DROP, RAISE).
- States and `fake_switch` level:
  - IDLE: level is 1 if `cur_color` ≠ 0, else 0.
  - DROP: 0 for GAP_TICKS.
  - RAISE: 1 for HOLD_TICKS. At the end of RAISE, `cur_color` becomes 1 if it was 0, otherwise it advances one step in the cycle.
  - OFF: 0 for OFF_TICKS. At the end, `cur_color` = 0.
  - DONE: one cycle, `done`=1, then IDLE.
- Remaining steps are held in a 2-bit down-counter. The phase counter is 16 bits wide and counts ticks.

## Timing
- The tick prescaler is cleared on acceptance. Every phase therefore lasts exactly N×DIV Sys_CLK cycles.
- The first phase level appears on `fake_switch` in the cycle after acceptance. `busy` rises in that same cycle.
- DONE is the cycle after the last phase ends. In that cycle `busy`=0 and `req_ready`=1, so a new request may be accepted in the DONE cycle.
- For the target == cur case, DONE is the cycle after acceptance.
- Reset mid-operation: the next cycle is the full reset state, with `fake_switch`=0. The lamp then times out to off, which matches `cur_color`=0.
- If reset and `req_valid` occur together, reset wins and the request is dropped.
- `done` and `busy` are never both 1.

## Configuration
- `SEQ_RESYNC_EN` defined: every accepted non-zero request whose target ≠ cur, and for which cur ≠ 0, starts with an OFF phase. It then runs the cur == 0 plan. This bounds model drift at the cost of the OFF time.
- `SEQ_RESYNC_EN` undefined: the minimum-step plan described above.

## Test plan
Bench parameters: DIV=2, HOLD_TICKS=3, GAP_TICKS=3, OFF_TICKS=5 (one phase = 6 or 10 cycles).
- Reset, then request 3 from off -> `fake_switch` runs high 6, low 6, high 6, low 6, high 6 cycles. `done` pulses at cycle 31 after acceptance. `cur_color`=3 and `fake_switch` stays 1.
- From 3, request 2 -> 2 steps: low 6, high 6, low 6, high 6. `done` at cycle 25. `cur_color`=2.
- From 2, request 0 -> low for 10 cycles. `done` at cycle 11. `cur_color`=0 and `fake_switch` stays 0.
- Request equal to `cur_color` -> `done` the cycle after acceptance. `fake_switch` does not toggle. Also assert `req_valid` while busy -> the request is ignored and `cur_color` matches only the first target.
- Assert `Sys_RST` mid-DROP of a 1→3 sequence -> next cycle `fake_switch`=0, `busy`=0, `cur_color`=0, `req_ready`=1.
- With `SEQ_RESYNC_EN`, from 3 request 1 -> low 10, high 6. `done` at cycle 17. `cur_color`=1.

Source files
------------

// File: rtl/switch_sequencer.sv
// switch_sequencer: drives the lamp switch line with the shortest toggle sequence that reaches a requested colour
// Ports: Sys_CLK/Sys_RST clock and sync active-high reset; req_valid/req_color/req_ready request handshake;
//        busy sequence running; done one-cycle completion pulse; cur_color modelled lamp colour;
//        fake_switch line to the lamp. Define SEQ_RESYNC_EN to force an OFF phase before lit-to-lit changes.
module switch_sequencer #(
  parameter int DIV        = 5000,
  parameter int HOLD_TICKS = 2000,
  parameter int GAP_TICKS  = 2000,
  parameter int OFF_TICKS  = 15000
) (
  input  logic       Sys_CLK,
  input  logic       Sys_RST,
  input  logic       req_valid,
  input  logic [1:0] req_color,
  output logic       req_ready,
  output logic       busy,
  output logic       done,
  output logic [1:0] cur_color,
  output logic       fake_switch
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] DROP  = 3'd1;
  localparam logic [2:0] RAISE = 3'd2;
  localparam logic [2:0] OFF   = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  logic [2:0]  state;
  logic [1:0]  target, steps, next_color;
  logic [15:0] div_cnt, tick_cnt, last;
  logic        accept, tick, phase_end;
`ifndef SEQ_RESYNC_EN
  logic [2:0] diff;
  logic [1:0] fwd;
  assign diff = {1'b0, req_color} + 3'd3 - {1'b0, cur_color};
  assign fwd  = diff >= 3'd3 ? 2'(diff - 3'd3) : diff[1:0];
`endif
  assign busy        = state == DROP || state == RAISE || state == OFF;
  assign done        = state == DONE;
  assign req_ready   = ~busy;
  assign accept      = req_valid && req_ready;
  assign tick        = div_cnt == 16'(DIV - 1);
  assign last        = state == DROP ? 16'(GAP_TICKS - 1) : state == RAISE ? 16'(HOLD_TICKS - 1) : 16'(OFF_TICKS - 1);
  assign phase_end   = busy && tick && tick_cnt == last;
  // off lights white on its first raise; lit colours wrap 3 -> 1
  assign next_color  = cur_color == 2'd3 ? 2'd1 : cur_color + 2'd1;
  assign fake_switch = state == RAISE || ((state == IDLE || state == DONE) && cur_color != 2'd0);
  // steps holds the (DROP, RAISE) pairs still owed after the current phase
  always_ff @(posedge Sys_CLK)
    if (Sys_RST) begin
      state     <= IDLE;
      cur_color <= 2'd0;
      target    <= 2'd0;
      steps     <= 2'd0;
      div_cnt   <= '0;
      tick_cnt  <= '0;
    end else if (accept) begin
      target   <= req_color;
      div_cnt  <= '0;
      tick_cnt <= '0;
      if (req_color == cur_color) state <= DONE;
      else if (req_color == 2'd0) state <= OFF;
      else if (cur_color == 2'd0) begin
        state <= RAISE;
        steps <= req_color - 2'd1;
      end else begin
`ifdef SEQ_RESYNC_EN
        state <= OFF;
`else
        state <= DROP;
        steps <= fwd - 2'd1;
`endif
      end
    end else if (busy) begin
      if (phase_end) begin
        div_cnt  <= '0;
        tick_cnt <= '0;
        case (state)
          DROP: state <= RAISE;
          RAISE: begin
            cur_color <= next_color;
            state     <= steps == 2'd0 ? DONE : DROP;
            steps     <= steps == 2'd0 ? steps : steps - 2'd1;
          end
          default: begin
            cur_color <= 2'd0;
            state     <= target == 2'd0 ? DONE : RAISE;
            steps     <= target - 2'd1;
          end
        endcase
      end else begin
        div_cnt  <= tick ? '0 : div_cnt + 16'd1;
        tick_cnt <= tick ? tick_cnt + 16'd1 : tick_cnt;
      end
    end else if (state == DONE) state <= IDLE;
endmodule

// File: tb/tb_switch_sequencer.sv
// tb_switch_sequencer: scoreboard bench for switch_sequencer against a phase-list model of the toggle protocol
module tb_switch_sequencer;
  localparam int DIV = 2, HT = 3, GT = 3, OT = 5;
  logic Sys_CLK = 0, Sys_RST = 1, req_valid = 0;
  logic [1:0] req_color = 0;
  logic req_ready, busy, done, fake_switch;
  logic [1:0] cur_color;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {int done_cyc; logic [1:0] color;} exp_t;
  exp_t sb[$];
  bit wave[$];
  logic [1:0] mdl = 0, idle_col = 0;

  switch_sequencer #(.DIV(DIV), .HOLD_TICKS(HT), .GAP_TICKS(GT), .OFF_TICKS(OT)) dut (
    .Sys_CLK(Sys_CLK), .Sys_RST(Sys_RST), .req_valid(req_valid), .req_color(req_color),
    .req_ready(req_ready), .busy(busy), .done(done), .cur_color(cur_color), .fake_switch(fake_switch));

  always #5 Sys_CLK = ~Sys_CLK;
  always @(posedge Sys_CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic void push_level(bit lvl, int n);
    repeat (n) wave.push_back(lvl);
  endfunction

  // lamp model: an accepted request becomes a list of line levels, one per busy cycle
  function automatic void model_accept(logic [1:0] t, int c);
    int s0, pairs;
    logic [1:0] m;
    exp_t e;
    s0 = wave.size();
    m = mdl;
    if (t != m) begin
      if (t == 0) push_level(0, OT * DIV);
      else begin
`ifdef SEQ_RESYNC_EN
        if (m != 0) begin
          push_level(0, OT * DIV);
          m = 0;
        end
`endif
        if (m == 0) begin
          push_level(1, HT * DIV);
          pairs = int'(t) - 1;
        end else pairs = (int'(t) - int'(m) + 3) % 3;
        repeat (pairs) begin
          push_level(0, GT * DIV);
          push_level(1, HT * DIV);
        end
      end
    end
    e.done_cyc = c + (wave.size() - s0) + 1;
    e.color = t;
    sb.push_back(e);
    mdl = t;
  endfunction

  // entered and left at posedge + #1
  task automatic send(input logic [1:0] t, output bit acc);
    req_valid = 1;
    req_color = t;
    @(negedge Sys_CLK);
    acc = req_ready;
    if (acc) model_accept(t, cyc);
    @(posedge Sys_CLK) #1;
    req_valid = 0;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (busy && n < 500) begin
      @(posedge Sys_CLK) #1;
      n++;
    end
    if (n >= 500) chk("idle_timeout", 1, 0);
  endtask

  always @(negedge Sys_CLK)
    if (!Sys_RST) begin
      chk("done_busy_excl", done && busy, 0);
      if (busy) begin
        if (wave.size() == 0) chk("wave_underflow", 1, 0);
        else chk("wave", fake_switch, wave.pop_front());
      end else begin
        if (done) begin
          if (sb.size() == 0) chk("unexpected_done", 1, 0);
          else begin
            exp_t e;
            e = sb.pop_front();
            chk("done_cycle", cyc, e.done_cyc);
            chk("done_color", cur_color, e.color);
            idle_col = e.color;
          end
        end
        chk("idle_level", fake_switch, idle_col != 0);
      end
    end

  initial begin
    bit acc;
    @(posedge Sys_CLK) #1;
    @(negedge Sys_CLK);
    chk("rst_switch", fake_switch, 0);
    chk("rst_color", cur_color, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", req_ready, 1);
    @(posedge Sys_CLK) #1;
    Sys_RST = 0;
    @(posedge Sys_CLK) #1;
    send(3, acc); chk("acc_0to3", acc, 1); wait_idle; chk("col_3", cur_color, 3);
    send(2, acc); chk("acc_3to2", acc, 1); wait_idle; chk("col_2", cur_color, 2);
    send(0, acc); chk("acc_2to0", acc, 1); wait_idle; chk("col_0", cur_color, 0);
    send(2, acc); chk("acc_0to2", acc, 1);
    repeat (3) @(posedge Sys_CLK) #1;
    send(1, acc); chk("busy_ignored", acc, 0);
    wait_idle; chk("col_first_only", cur_color, 2);
    send(2, acc); chk("acc_same", acc, 1);
    repeat (3) @(posedge Sys_CLK) #1;
    send(3, acc); chk("acc_2to3", acc, 1); wait_idle;
    send(1, acc); chk("acc_3to1", acc, 1); wait_idle; chk("col_1", cur_color, 1);
    send(3, acc); chk("acc_1to3", acc, 1);
    repeat (3) @(posedge Sys_CLK) #1;
    Sys_RST = 1;
    sb.delete();
    wave.delete();
    mdl = 0;
    idle_col = 0;
    @(negedge Sys_CLK);
    @(negedge Sys_CLK);
    chk("mid_rst_switch", fake_switch, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_color", cur_color, 0);
    chk("mid_rst_ready", req_ready, 1);
    @(posedge Sys_CLK) #1;
    Sys_RST = 0;
    @(posedge Sys_CLK) #1;
    for (int i = 0; i < 60; i++) begin
      send(2'($urandom_range(0, 3)), acc);
      if ($urandom_range(0, 1) == 1) wait_idle;
      else repeat ($urandom_range(0, 12)) @(posedge Sys_CLK) #1;
    end
    wait_idle;
    repeat (3) @(posedge Sys_CLK) #1;
    chk("sb_drained", sb.size(), 0);
    chk("wave_drained", wave.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
